decode_cycle: RTL and testbench
===============================

Name: decode_cycle

Overview:
- Second stage of the 5-stage RV32I pipeline; consumes the IF/ID outputs of fetch_cycle (InstrD, PCD, PCPlus4D).
- Decodes control, extends the immediate and reads the 32x32 register file.
- Registers everything into the ID/EX boundary for execute_cycle.
- Also hosts the register-file write port driven by writeback, and honours a flush from execute when a branch or jump is taken (PCSrcE).

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_AW, 5, register address width; 32 registers.
- CLEAR_RF_ON_RESET, 1, when 1 every register-file entry is zeroed during reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- InstrD  input  32  instruction from IF/ID.
- PCD  input  32  PC of InstrD.
- PCPlus4D  input  32  PCD+4.
- RegWriteW  input  1  writeback write enable.
- RDW  input  5  writeback destination register.
- ResultW  input  32  writeback data.
- FlushE  input  1  squash the ID/EX contents; driven by PCSrcE.
- RegWriteE  output  1  register-write control.
- MemWriteE  output  1  store control.
- ResultSrcE  output  2  result select: 00 ALU, 01 memory, 10 PC+4.
- ALUSrcE  output  1  ALU operand B select: 1 selects the immediate.
- ALUControlE  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- BranchE  output  1  beq.
- JumpE  output  1  jal.
- RD1E  output  32  rs1 data.
- RD2E  output  32  rs2 data.
- ImmExtE  output  32  sign-extended immediate.
- Rs1E  output  5  rs1 address.
- Rs2E  output  5  rs2 address.
- RdE  output  5  rd address.
- PCE  output  32  registered PCD.
- PCPlus4E  output  32  registered PCPlus4D.

Behaviour:
- Reset: at a rising edge with rst=0, all E outputs become 0. If CLEAR_RF_ON_RESET=1, all register-file entries become 0. Reset has priority over flush and over writes.
- Latency: D-side inputs appear on the E outputs exactly 1 cycle later. No stall input; ID/EX loads every cycle.
- Register file write: at a rising edge with RegWriteW=1 and RDW!=0, regfile[RDW] <= ResultW. Writes with RDW=0 are discarded; x0 always reads 0.
- Read is combinational on InstrD[19:15] and InstrD[24:20].
- Write-through bypass: if RegWriteW=1, RDW!=0 and RDW equals a read address in the same cycle, that read returns ResultW. The value captured into RD1E/RD2E is therefore the new value.
- Field decode: op=InstrD[6:0], rd=[11:7], f3=[14:12], rs1=[19:15], rs2=[24:20], f7b5=[30].
- Control per opcode (RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ALUOp):
  - lw 0000011: 1, I, 1, 0, 01, 0, 0, 00.
  - sw 0100011: 0, S, 1, 1, 00, 0, 0, 00.
  - R 0110011: 1, -, 0, 0, 00, 0, 0, 10.
  - I-ALU 0010011: 1, I, 1, 0, 00, 0, 0, 10.
  - beq 1100011: 0, B, 0, 0, 00, 1, 0, 01.
  - jal 1101111: 1, J, -, 0, 10, 0, 1, 00.
  - Any other opcode: every control output is 0 and ImmExt is 0 (bubble).
- ALU decode:
  - ALUOp 00 -> add; 01 -> sub.
  - ALUOp 10, by f3: 000 -> sub if R-type and f7b5=1, else add; 010 -> slt; 110 -> or; 111 -> and.
  - Any other f3 -> add.
- Immediate forms (all sign-extended from InstrD[31]):
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- Flush: at a rising edge with FlushE=1 and rst=1, all E outputs load 0. This is a full bubble, so RegWriteE=MemWriteE=BranchE=JumpE=0. Regfile writes in the same cycle still occur.
- Reset mid-operation: pending ID/EX contents are lost. A same-edge regfile write is suppressed when CLEAR_RF_ON_RESET=1.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> all E outputs 0; a read of x5 returns 0.
- addi: InstrD=32'h00A00293 (addi x5,x0,10) -> next cycle RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=10, RdE=5, RD1E=0.
- Bypass: InstrD=32'h00528333 (add x6,x5,x5) with RegWriteW=1, RDW=5, ResultW=32'h1234 in the same cycle -> next cycle RD1E=RD2E=32'h1234, ALUControlE=000, ResultSrcE=00.
- x0 write: RegWriteW=1, RDW=0, ResultW=32'hFFFFFFFF -> a later read of x0 gives RD1E=0.
- Immediates: beq 32'hFE000EE3 -> ImmExtE=32'hFFFFFFFC, BranchE=1, ALUControlE=001. jal 32'h008000EF -> ImmExtE=8, JumpE=1, ResultSrcE=10, RdE=1.
- Flush and illegal opcode:
  - FlushE=1 with a valid lw in InstrD -> next cycle every E output is 0.
  - InstrD=32'hFFFFFFFF -> all controls 0, ImmExtE=0.

Source files
------------

// File: rtl/decode_cycle.sv
// ---------------------------------------------------------------------------
// decode_cycle: instruction decode stage of a 5-stage RV32I pipeline.
//
// Decodes the control fields of InstrD, extends the immediate, reads the
// 32x32 register file and registers everything into the ID/EX boundary.
// It also owns the register-file write port that writeback drives.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   InstrD, PCD, PCPlus4D    IF/ID inputs (instruction, PC, PC+4)
//   RegWriteW, RDW, ResultW  writeback write port
//   FlushE                   squash the ID/EX register (taken branch/jump)
//   *E outputs               registered ID/EX contents for execute
//
// Handshake: none. ID/EX loads on every rising edge; there is no stall.
// ---------------------------------------------------------------------------
module decode_cycle #(
  parameter int DATA_W            = 32,
  parameter int REG_AW            = 5,
  parameter bit CLEAR_RF_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       InstrD,
  input  logic [DATA_W-1:0] PCD,
  input  logic [DATA_W-1:0] PCPlus4D,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              FlushE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic [1:0]        ResultSrcE,
  output logic              ALUSrcE,
  output logic [2:0]        ALUControlE,
  output logic              BranchE,
  output logic              JumpE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] ImmExtE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic [DATA_W-1:0] PCE,
  output logic [DATA_W-1:0] PCPlus4E
);

  localparam int NREGS = 1 << REG_AW;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4
  } imm_sel_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // Field extraction
  logic [6:0]        op;
  logic [2:0]        f3;
  logic              f7b5;
  logic [REG_AW-1:0] rs1, rs2, rd;

  assign op   = InstrD[6:0];
  assign rd   = InstrD[11:7];
  assign f3   = InstrD[14:12];
  assign rs1  = InstrD[19:15];
  assign rs2  = InstrD[24:20];
  assign f7b5 = InstrD[30];

  // Main decoder
  logic     reg_write_d, mem_write_d, alu_src_d, branch_d, jump_d;
  logic [1:0] result_src_d, alu_op;
  imm_sel_e imm_sel;

  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    alu_src_d    = 1'b0;
    branch_d     = 1'b0;
    jump_d       = 1'b0;
    result_src_d = 2'b00;
    alu_op       = 2'b00;
    imm_sel      = IMM_NONE;
    unique case (op)
      OP_LW: begin
        reg_write_d  = 1'b1;
        imm_sel      = IMM_I;
        alu_src_d    = 1'b1;
        result_src_d = 2'b01;
      end
      OP_SW: begin
        imm_sel     = IMM_S;
        alu_src_d   = 1'b1;
        mem_write_d = 1'b1;
      end
      OP_R: begin
        reg_write_d = 1'b1;
        alu_op      = 2'b10;
      end
      OP_IALU: begin
        reg_write_d = 1'b1;
        imm_sel     = IMM_I;
        alu_src_d   = 1'b1;
        alu_op      = 2'b10;
      end
      OP_BEQ: begin
        imm_sel  = IMM_B;
        branch_d = 1'b1;
        alu_op   = 2'b01;
      end
      OP_JAL: begin
        reg_write_d  = 1'b1;
        imm_sel      = IMM_J;
        result_src_d = 2'b10;
        jump_d       = 1'b1;
      end
      default: ; // unknown opcode decodes to a bubble
    endcase
  end

  // ALU decoder
  logic [2:0] alu_ctrl_d;

  always_comb begin
    alu_ctrl_d = 3'b000;
    unique case (alu_op)
      2'b01: alu_ctrl_d = 3'b001;
      2'b10: begin
        unique case (f3)
          // Only register-register ops use f7b5 to pick sub; addi ignores it.
          3'b000:  alu_ctrl_d = (op == OP_R && f7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl_d = 3'b101;
          3'b110:  alu_ctrl_d = 3'b011;
          3'b111:  alu_ctrl_d = 3'b010;
          default: alu_ctrl_d = 3'b000;
        endcase
      end
      default: alu_ctrl_d = 3'b000;
    endcase
  end

  // Immediate extension, sign taken from InstrD[31]
  logic [DATA_W-1:0] imm_ext_d;

  always_comb begin
    imm_ext_d = '0;
    unique case (imm_sel)
      IMM_I:   imm_ext_d = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm_ext_d = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm_ext_d = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                            InstrD[11:8], 1'b0};
      IMM_J:   imm_ext_d = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                            InstrD[30:21], 1'b0};
      default: imm_ext_d = '0;
    endcase
  end

  // Register file
  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_en;

  assign wr_en = RegWriteW && (RDW != '0);

  always_ff @(posedge clk) begin
    if (!rst && CLEAR_RF_ON_RESET) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[RDW] <= ResultW;
    end
  end

  // Combinational read with write-through so the same-cycle writeback value
  // is what reaches RD1E/RD2E; x0 is hardwired to zero.
  logic [DATA_W-1:0] rd1_d, rd2_d;

  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (rs1 != '0) rd1_d = (wr_en && RDW == rs1) ? ResultW : regs_q[rs1];
    if (rs2 != '0) rd2_d = (wr_en && RDW == rs2) ? ResultW : regs_q[rs2];
  end

  // ID/EX register
  always_ff @(posedge clk) begin
    if (!rst || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUSrcE     <= 1'b0;
      ALUControlE <= 3'b000;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      RegWriteE   <= reg_write_d;
      MemWriteE   <= mem_write_d;
      ResultSrcE  <= result_src_d;
      ALUSrcE     <= alu_src_d;
      ALUControlE <= alu_ctrl_d;
      BranchE     <= branch_d;
      JumpE       <= jump_d;
      RD1E        <= rd1_d;
      RD2E        <= rd2_d;
      ImmExtE     <= imm_ext_d;
      Rs1E        <= rs1;
      Rs2E        <= rs2;
      RdE         <= rd;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
module tb_decode_cycle;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RDW;
  logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .BranchE(BranchE),
    .JumpE(JumpE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every E output must be zero (reset / flush bubble).
  task automatic chk_all_zero(input string tag);
    chk({tag, ".ctrl"}, {23'd0, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE,
                         ALUControlE, BranchE, JumpE}, 32'd0);
    chk({tag, ".rd1"}, RD1E, 32'd0);
    chk({tag, ".rd2"}, RD2E, 32'd0);
    chk({tag, ".imm"}, ImmExtE, 32'd0);
    chk({tag, ".regs"}, {17'd0, Rs1E, Rs2E, RdE}, 32'd0);
    chk({tag, ".pc"}, PCE, 32'd0);
    chk({tag, ".pc4"}, PCPlus4E, 32'd0);
  endtask

  task automatic drive(input logic [31:0] instr, input logic we,
                       input logic [4:0] rdw, input logic [31:0] res);
    InstrD    = instr;
    RegWriteW = we;
    RDW       = rdw;
    ResultW   = res;
  endtask

  initial begin
    rst = 1'b0; FlushE = 1'b0;
    PCD = 32'h0000_0100; PCPlus4D = 32'h0000_0104;
    // Reset with a pending write to x5 that must be suppressed
    drive(32'h00A00293, 1'b1, 5'd5, 32'h0000_DEAD);
    step(); step();
    chk_all_zero("reset");

    // Read x5 after reset: cleared, write suppressed
    rst = 1'b1;
    drive(32'h00528333, 1'b0, 5'd0, 32'd0);
    step();
    chk("rst_x5.rd1", RD1E, 32'd0);
    chk("rst_x5.rd2", RD2E, 32'd0);
    chk("add.rd", {27'd0, RdE}, 32'd6);
    chk("add.rs", {22'd0, Rs1E, Rs2E}, {22'd0, 5'd5, 5'd5});
    chk("add.ctl", {29'd0, RegWriteE, ALUSrcE, MemWriteE}, 32'b100);

    // addi x5,x0,10
    PCD = 32'h0000_0200; PCPlus4D = 32'h0000_0204;
    drive(32'h00A00293, 1'b0, 5'd0, 32'd0);
    step();
    chk("addi.regwrite", {31'd0, RegWriteE}, 32'd1);
    chk("addi.alusrc", {31'd0, ALUSrcE}, 32'd1);
    chk("addi.aluctl", {29'd0, ALUControlE}, 32'd0);
    chk("addi.imm", ImmExtE, 32'd10);
    chk("addi.rd", {27'd0, RdE}, 32'd5);
    chk("addi.rd1", RD1E, 32'd0);
    chk("addi.pc", PCE, 32'h0000_0200);
    chk("addi.pc4", PCPlus4E, 32'h0000_0204);
    chk("addi.ressrc", {30'd0, ResultSrcE}, 32'd0);

    // Bypass: add x6,x5,x5 with same-cycle write x5=0x1234
    drive(32'h00528333, 1'b1, 5'd5, 32'h0000_1234);
    step();
    chk("bypass.rd1", RD1E, 32'h0000_1234);
    chk("bypass.rd2", RD2E, 32'h0000_1234);
    chk("bypass.aluctl", {29'd0, ALUControlE}, 32'd0);
    chk("bypass.ressrc", {30'd0, ResultSrcE}, 32'd0);

    // Write persisted into the file
    drive(32'h00528333, 1'b0, 5'd0, 32'd0);
    step();
    chk("persist.rd1", RD1E, 32'h0000_1234);

    // x0 write discarded, no bypass to x0
    drive(32'h00A00293, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    chk("x0_bypass.rd1", RD1E, 32'd0);
    drive(32'h00A00293, 1'b0, 5'd0, 32'd0);
    step();
    chk("x0_read.rd1", RD1E, 32'd0);

    // sub x7,x5,x6
    drive(32'h406283B3, 1'b0, 5'd0, 32'd0);
    step();
    chk("sub.aluctl", {29'd0, ALUControlE}, 32'd1);
    chk("sub.rd1", RD1E, 32'h0000_1234);
    chk("sub.rd2", RD2E, 32'd0);

    // beq with offset -4
    drive(32'hFE000EE3, 1'b0, 5'd0, 32'd0);
    step();
    chk("beq.imm", ImmExtE, 32'hFFFF_FFFC);
    chk("beq.branch", {31'd0, BranchE}, 32'd1);
    chk("beq.aluctl", {29'd0, ALUControlE}, 32'd1);
    chk("beq.ctl", {29'd0, RegWriteE, ALUSrcE, JumpE}, 32'd0);

    // jal x1, +8
    drive(32'h008000EF, 1'b0, 5'd0, 32'd0);
    step();
    chk("jal.imm", ImmExtE, 32'd8);
    chk("jal.jump", {31'd0, JumpE}, 32'd1);
    chk("jal.ressrc", {30'd0, ResultSrcE}, 32'b10);
    chk("jal.rd", {27'd0, RdE}, 32'd1);
    chk("jal.regwrite", {30'd0, RegWriteE, BranchE}, 32'b10);

    // lw x8,4(x5)
    drive(32'h0042A403, 1'b0, 5'd0, 32'd0);
    step();
    chk("lw.ressrc", {30'd0, ResultSrcE}, 32'b01);
    chk("lw.imm", ImmExtE, 32'd4);
    chk("lw.rd1", RD1E, 32'h0000_1234);
    chk("lw.aluctl", {29'd0, ALUControlE}, 32'd0);

    // sw x5,-8(x6)
    drive(32'hFE532C23, 1'b0, 5'd0, 32'd0);
    step();
    chk("sw.imm", ImmExtE, 32'hFFFF_FFF8);
    chk("sw.ctl", {29'd0, MemWriteE, RegWriteE, ALUSrcE}, 32'b101);
    chk("sw.rd2", RD2E, 32'h0000_1234);

    // slti x9,x5,-1
    drive(32'hFFF2A493, 1'b0, 5'd0, 32'd0);
    step();
    chk("slti.aluctl", {29'd0, ALUControlE}, 32'b101);
    chk("slti.imm", ImmExtE, 32'hFFFF_FFFF);

    // or x10,x5,x6
    drive(32'h0062E533, 1'b0, 5'd0, 32'd0);
    step();
    chk("or.aluctl", {29'd0, ALUControlE}, 32'b011);

    // andi x11,x5,15
    drive(32'h00F2F593, 1'b0, 5'd0, 32'd0);
    step();
    chk("andi.aluctl", {29'd0, ALUControlE}, 32'b010);
    chk("andi.imm", ImmExtE, 32'd15);

    // Flush with a valid lw; a same-cycle write to x6 still lands
    FlushE = 1'b1;
    drive(32'h0042A403, 1'b1, 5'd6, 32'h0000_0055);
    step();
    chk_all_zero("flush");
    FlushE = 1'b0;
    drive(32'h406283B3, 1'b0, 5'd0, 32'd0);
    step();
    chk("flush_write.rd2", RD2E, 32'h0000_0055);

    // Illegal opcode
    drive(32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    step();
    chk("illegal.ctrl", {23'd0, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE,
                         ALUControlE, BranchE, JumpE}, 32'd0);
    chk("illegal.imm", ImmExtE, 32'd0);
    chk("illegal.rd", {27'd0, RdE}, 32'd31);

    // Reset mid-operation with a pending write to x5
    rst = 1'b0;
    drive(32'h0042A403, 1'b1, 5'd5, 32'h0000_0099);
    step();
    chk_all_zero("midreset");
    rst = 1'b1;
    drive(32'h00528333, 1'b0, 5'd0, 32'd0);
    step();
    chk("midreset_x5.rd1", RD1E, 32'd0);
    chk("midreset_x6.rdE", {27'd0, RdE}, 32'd6);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
